rf_alu_seq: RTL and testbench

Multi-word arithmetic sequencer for the RF_plus_ALU datapath: accepts one command (add or subtract of 1–4 sixteen-bit words) and drives the register-file read/write addresses and ALU op lines one word per cycle. It chains carry/borrow through Pre_C (plain op on word 0, ADC/SBB on later words) and reports aggregate Z/N/C/V flags. It sits between the instruction decode/control logic and the RF_plus_ALU block; Write_Data of the datapath is tied to the ALU Y output externally.

---
 rtl/rf_alu_seq.sv | 184 ++++++++++++++++++
 tb/tb_rf_alu_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : rf_alu_seq
//  Brief    : Multi-word add/subtract sequencer for the RF_plus_ALU datapath.
//             Steps one 16-bit word per cycle, chaining carry/borrow through
//             Pre_C, and reports aggregate Z/N/C/V flags on completion.
//  Revision : 1.0  initial release
// ============================================================================
module rf_alu_seq #(
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              op,
    input  logic [CNT_W-1:0]  words,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    input  logic [ADDR_W-1:0] dst,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] Read_Addr_A,
    output logic [ADDR_W-1:0] Read_Addr_B,
    output logic [ADDR_W-1:0] Write_Addr,
    output logic              Write_En,
    output logic              Pre_C,
    output logic              ADC,
    output logic              SUB,
    output logic              SBB,
    output logic              Src_ALU_B,
    input  logic              Z,
    input  logic              N,
    input  logic              C,
    input  logic              V,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c,
    output logic              flag_v
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic                r_op;
    logic [CNT_W-1:0]    r_words;
    logic [ADDR_W-1:0]   r_src_a;
    logic [ADDR_W-1:0]   r_src_b;
    logic [ADDR_W-1:0]   r_dst;
    logic [CNT_W-1:0]    r_idx;
    logic                r_carry;
    logic                r_z_acc;
    logic                r_flag_z;
    logic                r_flag_n;
    logic                r_flag_c;
    logic                r_flag_v;

    logic                w_first;
    logic                w_last;
    logic                w_z_next;
    logic [ADDR_W-1:0]   w_idx_ext;

    assign w_first   = (r_idx == '0);
    assign w_last    = (r_idx == r_words);
    assign w_z_next  = w_first ? Z : (r_z_acc & Z);
    assign w_idx_ext = ADDR_W'(r_idx);

    assign flag_z    = r_flag_z;
    assign flag_n    = r_flag_n;
    assign flag_c    = r_flag_c;
    assign flag_v    = r_flag_v;

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath control decode from registered state
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        Read_Addr_A  = '0;
        Read_Addr_B  = '0;
        Write_Addr   = '0;
        Write_En     = 1'b0;
        Pre_C        = 1'b0;
        ADC          = 1'b0;
        SUB          = 1'b0;
        SBB          = 1'b0;
        Src_ALU_B    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy        = 1'b1;
                Read_Addr_A = r_src_a + w_idx_ext;
                Read_Addr_B = r_src_b + w_idx_ext;
                Write_Addr  = r_dst + w_idx_ext;
                // A clear aborts the word in flight so it never lands in the RF
                Write_En    = ~clr;
                if (w_first) begin
                    SUB = r_op;
                end else begin
                    ADC   = ~r_op;
                    SBB   = r_op;
                    Pre_C = r_carry;
                end
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Command capture, word index, carry chain and flag accumulation
    always_ff @(posedge clk) begin
        if (clr) begin
            r_op     <= 1'b0;
            r_words  <= '0;
            r_src_a  <= '0;
            r_src_b  <= '0;
            r_dst    <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_z_acc  <= 1'b0;
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
            r_flag_c <= 1'b0;
            r_flag_v <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_words <= words;
                        r_src_a <= src_a;
                        r_src_b <= src_b;
                        r_dst   <= dst;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    r_carry <= C;
                    r_z_acc <= w_z_next;
                    if (w_last) begin
                        // Publish flags at the final word; they hold until the
                        // next command finishes
                        r_flag_z <= w_z_next;
                        r_flag_n <= N;
                        r_flag_c <= C;
                        r_flag_v <= V;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_alu_seq
//  Brief    : Directed self-checking bench for rf_alu_seq with a behavioural
//             8x16 register file and ALU standing in for RF_plus_ALU.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rf_alu_seq;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic        op;
    logic [1:0]  words;
    logic [2:0]  src_a, src_b, dst;
    logic        busy, done, Write_En, Pre_C, ADC, SUB, SBB, Src_ALU_B;
    logic [2:0]  Read_Addr_A, Read_Addr_B, Write_Addr;
    logic        z_f, n_f, c_f, v_f;
    logic        flag_z, flag_n, flag_c, flag_v;

    logic [15:0] rf [0:7];
    logic        pl_en;
    logic [2:0]  pl_addr;
    logic [15:0] pl_data;
    logic [15:0] alu_a, alu_b, y;
    logic [16:0] alu_r;
    logic        alu_cin;

    int passed = 0;
    int total  = 0;
    int we_cnt = 0;
    int done_cnt = 0;

    rf_alu_seq #(.ADDR_W(3), .CNT_W(2)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .words(words),
        .src_a(src_a), .src_b(src_b), .dst(dst),
        .busy(busy), .done(done),
        .Read_Addr_A(Read_Addr_A), .Read_Addr_B(Read_Addr_B), .Write_Addr(Write_Addr),
        .Write_En(Write_En), .Pre_C(Pre_C), .ADC(ADC), .SUB(SUB), .SBB(SBB),
        .Src_ALU_B(Src_ALU_B),
        .Z(z_f), .N(n_f), .C(c_f), .V(v_f),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
    );

    always #5 clk = ~clk;

    // Register file: preload port for the bench, write port from the sequencer
    always @(posedge clk) begin
        if (pl_en) rf[pl_addr] <= pl_data;
        else if (Write_En) rf[Write_Addr] <= y;
    end

    // ALU: carry out on add, borrow out on subtract
    always_comb begin
        alu_a   = rf[Read_Addr_A];
        alu_b   = rf[Read_Addr_B];
        alu_cin = (ADC | SBB) ? Pre_C : 1'b0;
        if (SUB | SBB) alu_r = {1'b0, alu_a} - {1'b0, alu_b} - {16'd0, alu_cin};
        else           alu_r = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
        y   = alu_r[15:0];
        c_f = alu_r[16];
        z_f = (y == 16'd0);
        n_f = y[15];
        if (SUB | SBB) v_f = (alu_a[15] != alu_b[15]) && (y[15] != alu_a[15]);
        else           v_f = (alu_a[15] == alu_b[15]) && (y[15] != alu_a[15]);
    end

    // Advance one cycle, tallying writes and done pulses of the cycle left
    task automatic step();
        if (Write_En) we_cnt++;
        if (done) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic o, input logic [1:0] w, input logic [2:0] sa,
                         input logic [2:0] sb, input logic [2:0] d);
        op = o; words = w; src_a = sa; src_b = sb; dst = d;
        we_cnt = 0; done_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        step(); step();
        total++; if ({busy, done, Write_En, Pre_C, ADC, SUB, SBB, Src_ALU_B} !== 8'd0) $display("FAIL reset_ctrl got %b exp 00000000", {busy, done, Write_En, Pre_C, ADC, SUB, SBB, Src_ALU_B}); else passed++;
        total++; if ({Read_Addr_A, Read_Addr_B, Write_Addr} !== 9'd0) $display("FAIL reset_addr got %h exp 000", {Read_Addr_A, Read_Addr_B, Write_Addr}); else passed++;
        total++; if ({flag_z, flag_n, flag_c, flag_v} !== 4'd0) $display("FAIL reset_flags got %b exp 0000", {flag_z, flag_n, flag_c, flag_v}); else passed++;
        clr = 1'b0;
        step(); step();
        total++; if (busy !== 1'b0) $display("FAIL idle_hold busy got %b exp 0", busy); else passed++;
    endtask

    task automatic test_single_add();
        preload(3'd0, 16'h1234); preload(3'd1, 16'h2345); preload(3'd2, 16'h0000);
        issue(1'b0, 2'd0, 3'd0, 3'd1, 3'd2);
        total++; if ({busy, Write_En} !== 2'b11) $display("FAIL single_run got busy/we %b exp 11", {busy, Write_En}); else passed++;
        total++; if ({Read_Addr_A, Read_Addr_B, Write_Addr} !== {3'd0, 3'd1, 3'd2}) $display("FAIL single_addr got %o exp 012", {Read_Addr_A, Read_Addr_B, Write_Addr}); else passed++;
        total++; if ({ADC, SUB, SBB, Pre_C} !== 4'b0000) $display("FAIL single_ops got %b exp 0000", {ADC, SUB, SBB, Pre_C}); else passed++;
        step();
        total++; if ({done, busy, Write_En} !== 3'b100) $display("FAIL single_done got %b exp 100", {done, busy, Write_En}); else passed++;
        total++; if (rf[2] !== 16'h3579) $display("FAIL single_r2 got %h exp 3579", rf[2]); else passed++;
        total++; if (flag_z !== 1'b0) $display("FAIL single_flagz got %b exp 0", flag_z); else passed++;
        step();
        total++; if ({done, we_cnt, done_cnt} !== {1'b0, 32'd1, 32'd1}) $display("FAIL single_counts got done=%b we=%0d dn=%0d exp 0 1 1", done, we_cnt, done_cnt); else passed++;
    endtask

    task automatic test_carry_chain();
        preload(3'd0, 16'hFFFF); preload(3'd1, 16'h0001);
        preload(3'd2, 16'h0001); preload(3'd3, 16'h0000);
        issue(1'b0, 2'd1, 3'd0, 3'd2, 3'd4);
        total++; if ({ADC, Pre_C, Read_Addr_A, Read_Addr_B, Write_Addr} !== {2'b00, 3'd0, 3'd2, 3'd4}) $display("FAIL carry_w0 got %b exp 00000010100", {ADC, Pre_C, Read_Addr_A, Read_Addr_B, Write_Addr}); else passed++;
        step();
        total++; if ({ADC, Pre_C, Read_Addr_A, Read_Addr_B, Write_Addr} !== {2'b11, 3'd1, 3'd3, 3'd5}) $display("FAIL carry_w1 got %b exp 11001011101", {ADC, Pre_C, Read_Addr_A, Read_Addr_B, Write_Addr}); else passed++;
        step();
        total++; if ({rf[4], rf[5]} !== {16'h0000, 16'h0002}) $display("FAIL carry_result got %h exp 00000002", {rf[4], rf[5]}); else passed++;
        total++; if ({done, flag_z, flag_n, flag_c, flag_v} !== 5'b10000) $display("FAIL carry_flags got %b exp 10000", {done, flag_z, flag_n, flag_c, flag_v}); else passed++;
        step();
    endtask

    task automatic test_sub_borrow();
        preload(3'd0, 16'h8000); preload(3'd1, 16'h0001);
        preload(3'd2, 16'h8000); preload(3'd3, 16'h0001);
        preload(3'd4, 16'hFFFF); preload(3'd5, 16'hFFFF);
        issue(1'b1, 2'd1, 3'd0, 3'd2, 3'd4);
        total++; if ({SUB, SBB, ADC, Pre_C} !== 4'b1000) $display("FAIL sub_w0 got %b exp 1000", {SUB, SBB, ADC, Pre_C}); else passed++;
        step();
        total++; if ({SUB, SBB, ADC, Pre_C} !== 4'b0100) $display("FAIL sub_w1 got %b exp 0100", {SUB, SBB, ADC, Pre_C}); else passed++;
        step();
        total++; if ({rf[4], rf[5]} !== 32'h0) $display("FAIL sub_result got %h exp 00000000", {rf[4], rf[5]}); else passed++;
        total++; if ({done, flag_z, flag_c} !== 3'b110) $display("FAIL sub_flags got %b exp 110", {done, flag_z, flag_c}); else passed++;
        step();
    endtask

    task automatic test_wrap();
        preload(3'd7, 16'h0010); preload(3'd6, 16'h0020); preload(3'd0, 16'h0100);
        issue(1'b0, 2'd1, 3'd7, 3'd6, 3'd7);
        total++; if ({Read_Addr_A, Read_Addr_B, Write_Addr} !== {3'd7, 3'd6, 3'd7}) $display("FAIL wrap_w0 got %o exp 767", {Read_Addr_A, Read_Addr_B, Write_Addr}); else passed++;
        step();
        total++; if ({Read_Addr_A, Read_Addr_B, Write_Addr} !== {3'd0, 3'd7, 3'd0}) $display("FAIL wrap_w1 got %o exp 070", {Read_Addr_A, Read_Addr_B, Write_Addr}); else passed++;
        step();
        total++; if ({rf[7], rf[0]} !== {16'h0030, 16'h0130}) $display("FAIL wrap_result got %h exp 00300130", {rf[7], rf[0]}); else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        preload(3'd0, 16'h0000); preload(3'd1, 16'h0000); preload(3'd2, 16'h0000);
        preload(3'd3, 16'h0001); preload(3'd4, 16'h0000); preload(3'd5, 16'h0000);
        issue(1'b1, 2'd2, 3'd0, 3'd3, 3'd6);
        step();
        op = 1'b0; words = 2'd0; dst = 3'd3; start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        total++; if ({done, flag_z, flag_n, flag_c, flag_v} !== 5'b10110) $display("FAIL b2b_flags got %b exp 10110", {done, flag_z, flag_n, flag_c, flag_v}); else passed++;
        step();
        start = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL b2b_ignore_done busy got %b exp 0", busy); else passed++;
        step(); step();
        total++; if ({we_cnt, done_cnt} !== {32'd3, 32'd1}) $display("FAIL b2b_counts got we=%0d dn=%0d exp 3 1", we_cnt, done_cnt); else passed++;
        total++; if ({rf[6], rf[7], rf[0], rf[3]} !== 64'hFFFF_FFFF_FFFF_0001) $display("FAIL b2b_result got %h exp ffffffffffff0001", {rf[6], rf[7], rf[0], rf[3]}); else passed++;
    endtask

    task automatic test_clear_abort();
        preload(3'd0, 16'h0001); preload(3'd1, 16'h0002); preload(3'd2, 16'h0003); preload(3'd3, 16'h0004);
        preload(3'd4, 16'h0010); preload(3'd5, 16'h0020); preload(3'd6, 16'h0030); preload(3'd7, 16'h0040);
        issue(1'b0, 2'd3, 3'd0, 3'd4, 3'd4);
        step(); step();
        total++; if ({busy, Read_Addr_A, Write_Addr} !== {1'b1, 3'd2, 3'd6}) $display("FAIL clr_w2 got %b exp 1010110", {busy, Read_Addr_A, Write_Addr}); else passed++;
        clr = 1'b1;
        step();
        clr = 1'b0;
        total++; if ({busy, done, Write_En} !== 3'b000) $display("FAIL clr_idle got %b exp 000", {busy, done, Write_En}); else passed++;
        total++; if ({flag_z, flag_n, flag_c, flag_v} !== 4'b0000) $display("FAIL clr_flags got %b exp 0000", {flag_z, flag_n, flag_c, flag_v}); else passed++;
        step(); step();
        total++; if (done_cnt !== 0) $display("FAIL clr_nodone got %0d exp 0", done_cnt); else passed++;
        total++; if ({rf[4], rf[5], rf[6], rf[7]} !== 64'h0011_0022_0030_0040) $display("FAIL clr_rf got %h exp 0011002200300040", {rf[4], rf[5], rf[6], rf[7]}); else passed++;
        issue(1'b0, 2'd0, 3'd0, 3'd1, 3'd2);
        step();
        total++; if ({done, rf[2]} !== {1'b1, 16'h0003}) $display("FAIL clr_fresh got %h exp 10003", {done, rf[2]}); else passed++;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1);
    end

    initial begin
        clr = 1'b1; start = 1'b0; op = 1'b0; words = 2'd0;
        src_a = 3'd0; src_b = 3'd0; dst = 3'd0;
        pl_en = 1'b0; pl_addr = 3'd0; pl_data = 16'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_add();
        test_carry_chain();
        test_sub_borrow();
        test_wrap();
        test_back_to_back();
        test_clear_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
